// File: rtl/lock_code_entry_pkg.sv
// Shared definitions for the combination-lock code entry front end.
// Holds the FSM state encoding, default code width and counter sizing helper.
package lock_code_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_t;

    localparam int CODE_W_DEF = 3;

    // Bits needed for a down/up counter whose largest value is n-1; never 0.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lock_code_entry_debounce_bit.sv
// Two-flop synchroniser plus stability counter for one raw input pin.
// The debounced output flips only after DEBOUNCE consecutive disagreeing cycles.
module lock_code_entry_debounce_bit
    import lock_code_entry_pkg::*;
#(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int DW = cnt_w(DEBOUNCE);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE - 1);

    logic          sync_1;
    logic          sync_2;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db     <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= sync_2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lock_code_entry.sv
// Code entry front end: debounces switches and ENTER, strobes a captured code
// per clean press, and enforces a timed lockout after repeated failures.
//   state   | meaning
//   IDLE    | waiting for an ENTER rising edge to capture the code
//   HELD    | code captured, waiting for ENTER release
//   LOCKOUT | too many failures, entry ignored until the timer expires
module lock_code_entry
    import lock_code_entry_pkg::*;
#(
    parameter int CODE_W         = CODE_W_DEF,
    parameter int DEBOUNCE       = 8,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] sw_raw,
    input  logic              enter_raw,
    input  logic              attempt_ok,
    input  logic              attempt_fail,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              locked_out,
    output logic [1:0]        fail_cnt
);

    generate
        if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_tries
            $error("lock_code_entry: MAX_TRIES must be 1..3 to fit fail_cnt");
        end
        if (DEBOUNCE < 2) begin : g_bad_debounce
            $error("lock_code_entry: DEBOUNCE must be at least 2");
        end
        if (LOCKOUT_CYCLES < 2) begin : g_bad_lockout
            $error("lock_code_entry: LOCKOUT_CYCLES must be at least 2");
        end
    endgenerate

    localparam int TW = cnt_w(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    FAIL_MAX   = 2'(MAX_TRIES);

    // Bit CODE_W of the debounced bus carries ENTER.
    logic [CODE_W:0]   raw_bus;
    logic [CODE_W:0]   db_bus;
    logic [CODE_W-1:0] sw_db;
    logic              enter_db;
    logic              enter_db_d;
    logic              enter_rise;
    logic              trip;

    lock_state_t       state;
    logic [TW-1:0]     timer;

    assign raw_bus  = {enter_raw, sw_raw};
    assign sw_db    = db_bus[CODE_W-1:0];
    assign enter_db = db_bus[CODE_W];

    for (genvar i = 0; i <= CODE_W; i++) begin : g_db
        lock_code_entry_debounce_bit #(
            .DEBOUNCE (DEBOUNCE)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_bus[i]),
            .db    (db_bus[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_db_d <= 1'b0;
            enter_rise <= 1'b0;
        end else begin
            enter_db_d <= enter_db;
            enter_rise <= enter_db & ~enter_db_d;
        end
    end

    // ok beats fail, so only a lone fail can push the count to the limit.
    assign trip = attempt_fail && !attempt_ok && ((fail_cnt + 2'd1) == FAIL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            code       <= '0;
            code_valid <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= 2'd0;
            timer      <= '0;
        end else begin
            code_valid <= 1'b0;
            case (state)
                IDLE, HELD: begin
                    if (attempt_ok) begin
                        fail_cnt <= 2'd0;
                    end else if (attempt_fail) begin
                        fail_cnt <= fail_cnt + 2'd1;
                    end
                    if (trip) begin
                        state      <= LOCKOUT;
                        locked_out <= 1'b1;
                        timer      <= TIMER_LOAD;
                    end else if (state == IDLE) begin
                        if (enter_rise) begin
                            code       <= sw_db;
                            code_valid <= 1'b1;
                            state      <= HELD;
                        end
                    end else if (!enter_db) begin
                        state <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        fail_cnt   <= 2'd0;
                        locked_out <= 1'b0;
                        state      <= enter_db ? HELD : IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_entry.sv
// Directed bench for lock_code_entry: press latency, bounce rejection,
// failure counting, lockout timing and async reset during lockout.
module tb_lock_code_entry;

    localparam int CODE_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CODE_W-1:0] sw_raw;
    logic              enter_raw;
    logic              attempt_ok;
    logic              attempt_fail;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              locked_out;
    logic [1:0]        fail_cnt;

    int checks      = 0;
    int failures    = 0;
    int pulses      = 0;
    int cyc         = 0;
    int first_pulse = -1;

    lock_code_entry #(
        .CODE_W         (CODE_W),
        .DEBOUNCE       (8),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_raw       (sw_raw),
        .enter_raw    (enter_raw),
        .attempt_ok   (attempt_ok),
        .attempt_fail (attempt_fail),
        .code         (code),
        .code_valid   (code_valid),
        .locked_out   (locked_out),
        .fail_cnt     (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (code_valid) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fail_pulse();
        attempt_fail = 1'b1;
        tick();
        attempt_fail = 1'b0;
    endtask

    task automatic press_release();
        enter_raw = 1'b1;
        run(20);
        enter_raw = 1'b0;
        run(20);
    endtask

    initial begin
        rst_n        = 1'b0;
        sw_raw       = 3'b101;
        enter_raw    = 1'b0;
        attempt_ok   = 1'b0;
        attempt_fail = 1'b0;
        #23;
        check_eq("rst_code", int'(code), 0);
        check_eq("rst_valid", int'(code_valid), 0);
        check_eq("rst_locked", int'(locked_out), 0);
        check_eq("rst_fail_cnt", int'(fail_cnt), 0);
        rst_n = 1'b1;
        run(15);

        // Clean press: first high sample at edge 1, strobe after edge 12.
        enter_raw = 1'b1;
        cyc = 0; pulses = 0; first_pulse = -1;
        run(20);
        check_eq("press_pulses", pulses, 1);
        check_eq("press_latency", first_pulse, 12);
        check_eq("press_code", int'(code), 5);
        enter_raw = 1'b0;
        run(20);

        // Bounce: 3-cycle glitches never propagate.
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            enter_raw = 1'b1; run(3);
            enter_raw = 1'b0; run(3);
        end
        run(20);
        check_eq("bounce_pulses", pulses, 0);
        sw_raw = 3'b010;
        run(15);
        pulses = 0;
        enter_raw = 1'b1;
        run(20);
        check_eq("after_bounce_pulses", pulses, 1);
        check_eq("after_bounce_code", int'(code), 2);
        enter_raw = 1'b0;
        run(20);

        // Three failures, one per press, trigger lockout.
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            press_release();
            check_eq("pre_fail_locked", int'(locked_out), 0);
            fail_pulse();
            check_eq("fail_cnt_step", int'(fail_cnt), k);
        end
        check_eq("press_pulses_3", pulses, 3);
        check_eq("lockout_entered", int'(locked_out), 1);
        pulses = 0;
        fail_pulse();
        check_eq("fail_ignored_lockout", int'(fail_cnt), 3);
        enter_raw = 1'b1; run(20);
        enter_raw = 1'b0; run(30);
        run(12);
        check_eq("lockout_last_cycle", int'(locked_out), 1);
        tick();
        check_eq("lockout_expired", int'(locked_out), 0);
        check_eq("lockout_fail_clr", int'(fail_cnt), 0);
        check_eq("lockout_no_strobe", pulses, 0);
        check_eq("lockout_code_kept", int'(code), 2);

        // Simultaneous ok and fail: ok wins.
        fail_pulse();
        fail_pulse();
        check_eq("two_fails", int'(fail_cnt), 2);
        attempt_ok = 1'b1; attempt_fail = 1'b1;
        tick();
        attempt_ok = 1'b0; attempt_fail = 1'b0;
        check_eq("ok_wins_cnt", int'(fail_cnt), 0);
        check_eq("ok_wins_locked", int'(locked_out), 0);
        fail_pulse();
        check_eq("one_fail", int'(fail_cnt), 1);
        attempt_ok = 1'b1; tick(); attempt_ok = 1'b0;
        check_eq("ok_clears", int'(fail_cnt), 0);

        // ENTER held across lockout expiry: resume in HELD, no strobe.
        fail_pulse(); fail_pulse(); fail_pulse();
        check_eq("held_lock_entered", int'(locked_out), 1);
        pulses = 0;
        enter_raw = 1'b1;
        run(70);
        check_eq("held_expired", int'(locked_out), 0);
        run(20);
        check_eq("held_no_strobe", pulses, 0);
        enter_raw = 1'b0;
        run(20);
        sw_raw = 3'b110;
        run(15);
        enter_raw = 1'b1;
        run(20);
        check_eq("repress_pulses", pulses, 1);
        check_eq("repress_code", int'(code), 6);
        enter_raw = 1'b0;
        run(20);

        // Async reset in the middle of a lockout.
        fail_pulse(); fail_pulse(); fail_pulse();
        run(10);
        check_eq("mid_lock_locked", int'(locked_out), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_code", int'(code), 0);
        check_eq("async_rst_locked", int'(locked_out), 0);
        check_eq("async_rst_fail", int'(fail_cnt), 0);
        check_eq("async_rst_valid", int'(code_valid), 0);
        #20;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_locked", int'(locked_out), 0);
        check_eq("post_rst_fail", int'(fail_cnt), 0);
        run(15);
        pulses = 0;
        enter_raw = 1'b1;
        run(20);
        check_eq("post_rst_pulses", pulses, 1);
        check_eq("post_rst_code", int'(code), 6);
        enter_raw = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
